// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one byte-wide UART transmitter between
// NUM_REQ requesters. Each requester owns a one-byte holding register. A
// granted frame is an optional channel-ID header byte followed by the
// payload byte.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   req_valid   per-channel byte valid
//   req_data    per-channel byte, channel i in bits [8i+7:8i]
//   req_ready   per-channel holding register empty
//   tx_data     byte to transmitter (registered)
//   tx_valid    tx_data valid (registered)
//   tx_ready    transmitter accepts byte this cycle
//   grant_id    channel currently granted (registered)
//   busy        a frame is in progress
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter bit          HEADER_EN = 1'b1,
   parameter logic [7:0]  HDR_BASE  = 8'hA0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic [2:0]           grant_id,
   output logic                 busy
);

   localparam int unsigned IdxW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

   state_e                    state_q, state_d;
   logic [NUM_REQ-1:0][7:0]   hold_q, hold_d;
   logic [NUM_REQ-1:0]        hold_full_q, hold_full_d;
   logic [IdxW-1:0]           last_q, last_d;
   logic [IdxW-1:0]           gnt_q, gnt_d;
   logic [7:0]                tx_data_q, tx_data_d;
   logic                      tx_valid_q, tx_valid_d;

   logic                      pend;
   logic [IdxW-1:0]           sel;
   logic [IdxW-1:0]           cand;
   logic [NUM_REQ-1:0]        accept;
   logic [NUM_REQ-1:0]        clr;
   logic                      xfer;

   // Search starts just after the last served channel, so it ends up lowest priority.
   always_comb begin
      pend = 1'b0;
      sel  = '0;
      cand = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = IdxW'((32'(last_q) + k) % NUM_REQ);
         if (!pend && hold_full_q[cand]) begin
            pend = 1'b1;
            sel  = cand;
         end
      end
   end

   assign xfer   = tx_valid_q & tx_ready;
   assign accept = req_valid & ~hold_full_q;

   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      last_d     = last_q;
      gnt_d      = gnt_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      clr        = '0;

      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (accept[i]) hold_d[i] = req_data[8*i +: 8];
      end

      case (state_q)
         StIdle: begin
            tx_valid_d = 1'b0;
            if (pend) begin
               gnt_d      = sel;
               tx_valid_d = 1'b1;
               if (HEADER_EN) begin
                  tx_data_d = HDR_BASE | 8'(sel);
                  state_d   = StHdr;
               end else begin
                  tx_data_d = hold_q[sel];
                  state_d   = StData;
               end
            end
         end
         StHdr: begin
            // Payload follows the header with no bubble on tx_valid.
            if (xfer) begin
               tx_data_d = hold_q[gnt_q];
               state_d   = StData;
            end
         end
         StData: begin
            if (xfer) begin
               clr[gnt_q] = 1'b1;
               last_d     = gnt_q;
               tx_valid_d = 1'b0;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // A channel being cleared is full, so it cannot be loading in the same cycle.
      hold_full_d = (hold_full_q | accept) & ~clr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         hold_q      <= '0;
         hold_full_q <= '0;
         last_q      <= IdxW'(NUM_REQ - 1);
         gnt_q       <= '0;
         tx_data_q   <= 8'h00;
         tx_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         last_q      <= last_d;
         gnt_q       <= gnt_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
      end
   end

   assign req_ready = ~hold_full_q;
   assign tx_data   = tx_data_q;
   assign tx_valid  = tx_valid_q;
   assign grant_id  = 3'(gnt_q);
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (NUM_REQ=4, HEADER_EN=1, HDR_BASE=A0).
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [2:0]  grant_id;
   logic        busy;

   int n_pass  = 0;
   int n_total = 0;
   int xfer_cnt = 0;

   logic [10:0] exp_q[$];   // {grant_id, byte}

   uart_tx_arbiter #(
      .NUM_REQ  (4),
      .HEADER_EN(1'b1),
      .HDR_BASE (8'hA0)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_data (req_data),
      .req_ready(req_ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .grant_id (grant_id),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      tx_ready  = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic push(input logic [2:0] g, input logic [7:0] b);
      exp_q.push_back({g, b});
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         cyc();
         n++;
      end
      check("drain", exp_q.size(), 0);
      cyc();
      cyc();
   endtask

   // Monitor: pops the scoreboard on every transfer, checks stall stability.
   logic       stall_v = 1'b0;
   logic [7:0] stall_data = '0;
   logic [10:0] e;
   always @(negedge clk) begin
      if (rst) begin
         stall_v = 1'b0;
      end else begin
         if (stall_v) check("stall_hold", {tx_valid, tx_data}, {1'b1, stall_data});
         if (tx_valid && tx_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_tx: got %0h/%0h required none", grant_id, tx_data);
            end else begin
               e = exp_q.pop_front();
               check("tx_byte", {grant_id, tx_data}, e);
            end
         end
         stall_v    = tx_valid && !tx_ready;
         stall_data = tx_data;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] pat;
      int          base;
      int          n;
      logic        any_v;

      // 1: reset and idle
      do_reset();
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_grant", grant_id, 3'd0);
      for (int i = 0; i < 20; i++) begin
         check("idle_valid", tx_valid, 1'b0);
         check("idle_busy", busy, 1'b0);
         check("idle_ready", req_ready, 4'hF);
         cyc();
      end

      // 2: single frame on ch2
      tx_ready = 1'b1;
      push(3'd2, 8'hA2);
      push(3'd2, 8'h5A);
      req_valid = 4'b0100;
      req_data  = 32'h005A_0000;
      cyc();
      req_valid = '0;
      check("t2_valid_n1", tx_valid, 1'b0);
      check("t2_ready_n1", req_ready, 4'b1011);
      cyc();
      check("t2_valid_n2", tx_valid, 1'b1);
      check("t2_hdr", tx_data, 8'hA2);
      check("t2_grant", grant_id, 3'd2);
      check("t2_busy", busy, 1'b1);
      cyc();
      check("t2_payload", tx_data, 8'h5A);
      check("t2_ready_data", req_ready[2], 1'b0);
      cyc();
      check("t2_ready_back", req_ready, 4'hF);
      check("t2_valid_off", tx_valid, 1'b0);
      check("t2_busy_off", busy, 1'b0);
      drain(10);

      // 3: all four channels at once, one idle cycle between frames
      do_reset();
      tx_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         push(3'(c), 8'hA0 | 8'(c));
         push(3'(c), 8'h10 + 8'(c));
      end
      req_valid = 4'hF;
      req_data  = 32'h1312_1110;
      cyc();
      req_valid = '0;
      pat = '0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         pat = {pat[10:0], tx_valid};
      end
      check("t3_valid_pattern", pat, 12'b1101_1011_0110);
      drain(20);

      // 4: tx_ready high one cycle in three during a ch1 frame
      do_reset();
      base = xfer_cnt;
      push(3'd1, 8'hA1);
      push(3'd1, 8'h77);
      req_valid = 4'b0010;
      req_data  = 32'h0000_7700;
      cyc();
      req_valid = '0;
      for (int i = 0; i < 15; i++) begin
         tx_ready = (i % 3 == 2);
         cyc();
      end
      tx_ready = 1'b0;
      drain(5);
      check("t4_xfers", xfer_cnt - base, 2);
      check("t4_ready", req_ready, 4'hF);

      // 5: ch0 reloads as soon as it can; ch3 must be served first
      do_reset();
      tx_ready = 1'b1;
      push(3'd0, 8'hA0);
      push(3'd0, 8'h01);
      push(3'd3, 8'hA3);
      push(3'd3, 8'h31);
      push(3'd0, 8'hA0);
      push(3'd0, 8'h02);
      req_valid = 4'b1001;
      req_data  = 32'h3100_0001;
      cyc();
      req_valid = '0;
      n = 0;
      while (!req_ready[0] && n < 20) begin
         cyc();
         n++;
      end
      check("t5_ch0_ready_back", req_ready[0], 1'b1);
      req_valid = 4'b0001;
      req_data  = 32'h0000_0002;
      cyc();
      req_valid = '0;
      drain(40);

      // 6: reset in DATA with ch1, ch2 held
      do_reset();
      push(3'd1, 8'hA1);
      req_valid = 4'b0110;
      req_data  = 32'h0022_1100;
      cyc();
      req_valid = '0;
      cyc();
      check("t6_hdr_valid", tx_valid, 1'b1);
      tx_ready = 1'b1;
      cyc();
      tx_ready = 1'b0;
      check("t6_in_data", tx_data, 8'h11);
      check("t6_busy", busy, 1'b1);
      rst = 1'b1;
      cyc();
      check("t6_rst_valid", tx_valid, 1'b0);
      check("t6_rst_ready", req_ready, 4'hF);
      check("t6_rst_busy", busy, 1'b0);
      check("t6_rst_data", tx_data, 8'h00);
      rst = 1'b0;
      exp_q.delete();
      tx_ready = 1'b1;
      any_v = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         any_v = any_v | tx_valid;
      end
      check("t6_no_stale", any_v, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
